// File: rtl/resp_bus_arbiter_pkg.sv
// Shared definitions for the uplink response arbiter.
//   - BUS_W     : width of the uplink data and len fields
//   - SRC_*     : source IDs, matching the downlink header classes
//   - state_t   : arbiter FSM encoding
//   - src_onehot / onehot_src : conversions between source ID and grant vector
package resp_bus_arbiter_pkg;

   localparam int BUS_W = 8;

   localparam logic [1:0] SRC_ADC   = 2'd0;
   localparam logic [1:0] SRC_FLASH = 2'd1;
   localparam logic [1:0] SRC_CTRL  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_XFER  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   function automatic logic [2:0] src_onehot(input logic [1:0] src);
      logic [2:0] oh;
      oh = 3'b000;
      case (src)
         SRC_ADC:   oh = 3'b001;
         SRC_FLASH: oh = 3'b010;
         SRC_CTRL:  oh = 3'b100;
         default:   oh = 3'b000;
      endcase
      return oh;
   endfunction

   function automatic logic [1:0] onehot_src(input logic [2:0] oh);
      logic [1:0] src;
      src = SRC_ADC;
      if (oh[1]) src = SRC_FLASH;
      if (oh[2]) src = SRC_CTRL;
      return src;
   endfunction

endpackage

// File: rtl/resp_bus_arbiter_if.sv
// Bundle of the three sink-side request/packet buses and the shared uplink.
//   sink side (per adc/flash/ctrl): req, grant, data, len, last, valid
//   uplink: o_up_data, o_up_len, o_up_last, o_up_valid
//   status: o_busy, o_timeout, o_len_err
// Handshake: a sink holds req until its grant rises, then streams beats
// with valid=1 (gaps with valid=0 allowed); last=1 marks the final beat.
// There is no backpressure: every granted valid beat is taken and shows up
// on the uplink exactly one cycle later.
// Modports: slave = arbiter side, master = sink/uplink-consumer side.
interface resp_bus_arbiter_if;
   import resp_bus_arbiter_pkg::*;

   logic             i_adc_req,   o_adc_grant,   i_adc_last,   i_adc_valid;
   logic [BUS_W-1:0] i_adc_data,  i_adc_len;
   logic             i_flash_req, o_flash_grant, i_flash_last, i_flash_valid;
   logic [BUS_W-1:0] i_flash_data, i_flash_len;
   logic             i_ctrl_req,  o_ctrl_grant,  i_ctrl_last,  i_ctrl_valid;
   logic [BUS_W-1:0] i_ctrl_data, i_ctrl_len;

   logic [BUS_W-1:0] o_up_data, o_up_len;
   logic             o_up_last, o_up_valid;
   logic             o_busy, o_timeout, o_len_err;

   modport slave (
      input  i_adc_req, i_adc_data, i_adc_len, i_adc_last, i_adc_valid,
      input  i_flash_req, i_flash_data, i_flash_len, i_flash_last, i_flash_valid,
      input  i_ctrl_req, i_ctrl_data, i_ctrl_len, i_ctrl_last, i_ctrl_valid,
      output o_adc_grant, o_flash_grant, o_ctrl_grant,
      output o_up_data, o_up_len, o_up_last, o_up_valid,
      output o_busy, o_timeout, o_len_err
   );

   modport master (
      output i_adc_req, i_adc_data, i_adc_len, i_adc_last, i_adc_valid,
      output i_flash_req, i_flash_data, i_flash_len, i_flash_last, i_flash_valid,
      output i_ctrl_req, i_ctrl_data, i_ctrl_len, i_ctrl_last, i_ctrl_valid,
      input  o_adc_grant, o_flash_grant, o_ctrl_grant,
      input  o_up_data, o_up_len, o_up_last, o_up_valid,
      input  o_busy, o_timeout, o_len_err
   );

endinterface

// File: rtl/resp_bus_arbiter_rr_pick3.sv
// Combinational three-way round-robin picker.
//   i_req[2:0]     : request vector (bit index = source ID)
//   i_last_winner  : source ID that won the previous arbitration
//   o_winner[2:0]  : one-hot winner, zero when no request
// The search starts at the source after i_last_winner, order adc, flash, ctrl.
module rr_pick3
   import resp_bus_arbiter_pkg::*;
(
   input  logic [2:0] i_req,
   input  logic [1:0] i_last_winner,
   output logic [2:0] o_winner
);

   always_comb begin
      o_winner = 3'b000;
      case (i_last_winner)
         SRC_ADC: begin
            if      (i_req[1]) o_winner = 3'b010;
            else if (i_req[2]) o_winner = 3'b100;
            else if (i_req[0]) o_winner = 3'b001;
         end
         SRC_FLASH: begin
            if      (i_req[2]) o_winner = 3'b100;
            else if (i_req[0]) o_winner = 3'b001;
            else if (i_req[1]) o_winner = 3'b010;
         end
         default: begin
            if      (i_req[0]) o_winner = 3'b001;
            else if (i_req[1]) o_winner = 3'b010;
            else if (i_req[2]) o_winner = 3'b100;
         end
      endcase
   end

endmodule

// File: rtl/resp_bus_arbiter.sv
// Packet-level round-robin arbiter sharing one uplink between adc, flash
// and ctrl. A granted sink streams one packet; each valid beat is forwarded
// with one registered cycle of latency. A start/stall timeout aborts a
// grant, and the beat count at last is checked against the len field.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : sink buses, uplink and status (resp_bus_arbiter_if.slave)
//   o_dbg_state    : current FSM state
module resp_bus_arbiter
   import resp_bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT    = 64,
   parameter int GAP_CYCLES = 1
)(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   resp_bus_arbiter_if.slave     bus,
   output state_t                o_dbg_state
);

   localparam int               TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES - 1);
   // Where a finished or aborted packet leads.
   localparam state_t           ST_POST  = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

   state_t           state_q, state_d;
   logic [1:0]       owner_q, owner_d;     // doubles as the RR pointer
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [7:0]       beat_q, beat_d;
   logic [7:0]       len_q, len_d;
   logic [3:0]       gap_q, gap_d;
   logic             tmo_pulse_d, len_err_d;

   logic [BUS_W-1:0] up_data_q, up_len_q;
   logic             up_last_q, up_valid_q, timeout_q, len_err_q;

   logic [2:0]       req, winner, grant;
   logic [BUS_W-1:0] sel_data, sel_len;
   logic             sel_last, sel_valid, owned, beat;

   assign req = {bus.i_ctrl_req, bus.i_flash_req, bus.i_adc_req};

   rr_pick3 u_pick (
      .i_req         (req),
      .i_last_winner (owner_q),
      .o_winner      (winner)
   );

   // Only the owner's bus is ever looked at, so foreign valids cannot leak.
   always_comb begin
      sel_data  = bus.i_adc_data;
      sel_len   = bus.i_adc_len;
      sel_last  = bus.i_adc_last;
      sel_valid = bus.i_adc_valid;
      case (owner_q)
         SRC_FLASH: begin
            sel_data  = bus.i_flash_data;
            sel_len   = bus.i_flash_len;
            sel_last  = bus.i_flash_last;
            sel_valid = bus.i_flash_valid;
         end
         SRC_CTRL: begin
            sel_data  = bus.i_ctrl_data;
            sel_len   = bus.i_ctrl_len;
            sel_last  = bus.i_ctrl_last;
            sel_valid = bus.i_ctrl_valid;
         end
         default: ;
      endcase
   end

   assign owned = (state_q == ST_GRANT) || (state_q == ST_XFER);
   assign beat  = owned && sel_valid;
   assign grant = owned ? src_onehot(owner_q) : 3'b000;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      tmo_d       = tmo_q;
      beat_d      = beat_q;
      len_d       = len_q;
      gap_d       = gap_q;
      tmo_pulse_d = 1'b0;
      len_err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               owner_d = onehot_src(winner);
               tmo_d   = '0;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT, ST_XFER: begin
            if (sel_valid) begin
               tmo_d = '0;
               // First beat (in GRANT) restarts the count and captures len.
               if (state_q == ST_GRANT) begin
                  beat_d = 8'd1;
                  len_d  = sel_len;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
               if (sel_last) begin
                  len_err_d = (state_q == ST_GRANT) ? (sel_len != 8'd1)
                                                    : (beat_q + 8'd1 != len_q);
                  gap_d     = '0;
                  state_d   = ST_POST;
               end else begin
                  state_d   = ST_XFER;
               end
            end else if (tmo_q == TMO_LAST) begin
               tmo_pulse_d = 1'b1;
               gap_d       = '0;
               state_d     = ST_POST;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) state_d = ST_IDLE;
            else                   gap_d   = gap_q + 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= SRC_CTRL;    // adc searched first after reset
         tmo_q      <= '0;
         beat_q     <= '0;
         len_q      <= '0;
         gap_q      <= '0;
         up_data_q  <= '0;
         up_len_q   <= '0;
         up_last_q  <= 1'b0;
         up_valid_q <= 1'b0;
         timeout_q  <= 1'b0;
         len_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         tmo_q      <= tmo_d;
         beat_q     <= beat_d;
         len_q      <= len_d;
         gap_q      <= gap_d;
         up_data_q  <= beat ? sel_data : '0;
         up_len_q   <= beat ? sel_len  : '0;
         up_last_q  <= beat && sel_last;
         up_valid_q <= beat;
         timeout_q  <= tmo_pulse_d;
         len_err_q  <= len_err_d;
      end
   end

   assign bus.o_adc_grant   = grant[0];
   assign bus.o_flash_grant = grant[1];
   assign bus.o_ctrl_grant  = grant[2];
   assign bus.o_up_data     = up_data_q;
   assign bus.o_up_len      = up_len_q;
   assign bus.o_up_last     = up_last_q;
   assign bus.o_up_valid    = up_valid_q;
   assign bus.o_busy        = owned;
   assign bus.o_timeout     = timeout_q;
   assign bus.o_len_err     = len_err_q;
   assign o_dbg_state       = state_q;

endmodule
